// File: rtl/sensor_row_readout.sv
// Row readout for the pixel array: captures a row on each completed row-select window,
// queues up to two rows and serialises them one pixel per valid/ready transfer.
module sensor_row_readout #(
    parameter  int PIXEL_ARRAY_WIDTH  = 4,
    parameter  int PIXEL_ARRAY_HEIGHT = 4,
    localparam int COL_W = $clog2(PIXEL_ARRAY_WIDTH),
    localparam int ROW_W = $clog2(PIXEL_ARRAY_HEIGHT)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]   row_select,
    input  logic [PIXEL_ARRAY_WIDTH*8-1:0]  row_data,
    output logic [7:0]                      px_data,
    output logic                            px_valid,
    input  logic                            px_ready,
    output logic [ROW_W-1:0]                px_row,
    output logic [COL_W-1:0]                px_col,
    output logic                            px_sof,
    output logic                            px_eol,
    output logic                            px_eof,
    output logic                            overflow,
    output logic                            sel_error
);

    localparam int DATA_W  = PIXEL_ARRAY_WIDTH * 8;
    localparam int ENTRY_W = ROW_W + DATA_W;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIXEL_ARRAY_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [PIXEL_ARRAY_HEIGHT-1:0] SEL_ONE = {{(PIXEL_ARRAY_HEIGHT-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [PIXEL_ARRAY_HEIGHT-1:0] r_row_sel_q;
    logic [DATA_W-1:0]             r_shadow_data;
    logic [ROW_W-1:0]              r_shadow_idx;
    logic [ENTRY_W-1:0]            r_fifo [2];
    logic                          r_wr_ptr;
    logic                          r_rd_ptr;
    logic [1:0]                    r_count;
    logic [COL_W-1:0]              r_col;
    logic                          r_overflow;
    logic                          r_sel_error;

    logic                          w_commit;
    logic                          w_onehot;
    logic                          w_px_valid;
    logic                          w_xfer;
    logic                          w_pop;
    logic                          w_push;
    logic                          w_drop;
    logic [1:0]                    w_count_nxt;
    logic [ENTRY_W-1:0]            w_head;
    logic [DATA_W-1:0]             w_head_data;
    logic [ROW_W-1:0]              w_head_idx;

    // One-hot select to binary row index; zero for an all-zero select.
    function automatic logic [ROW_W-1:0] f_sel_encode(input logic [PIXEL_ARRAY_HEIGHT-1:0] sel);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
            if (sel[i]) begin
                idx = idx | ROW_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Commit, push/pop arbitration and next state of the serialiser.
    always_comb begin
        w_commit    = (r_row_sel_q != '0) && (row_select != r_row_sel_q);
        w_onehot    = ((r_row_sel_q & (r_row_sel_q - SEL_ONE)) == '0);
        w_px_valid  = (r_state == ST_STREAM);
        w_xfer      = w_px_valid && px_ready;
        w_pop       = w_xfer && (r_col == COL_LAST);
        // A full FIFO still accepts the row when the head finishes on this same edge.
        w_push      = w_commit && w_onehot && ((r_count != 2'd2) || w_pop);
        w_drop      = w_commit && w_onehot && !w_push;
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_state_nxt = (w_count_nxt != 2'd0) ? ST_STREAM : ST_EMPTY;
    end

    // Serialiser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row capture, FIFO, column counter and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_sel_q   <= '0;
            r_shadow_data <= '0;
            r_shadow_idx  <= '0;
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_col         <= '0;
            r_overflow    <= 1'b0;
            r_sel_error   <= 1'b0;
        end else begin
            r_row_sel_q <= row_select;
            if (row_select != '0) begin
                r_shadow_data <= row_data;
                r_shadow_idx  <= f_sel_encode(row_select);
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {r_shadow_idx, r_shadow_data};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            if (w_xfer) begin
                r_col <= (r_col == COL_LAST) ? '0 : (r_col + COL_ONE);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_commit && !w_onehot) begin
                r_sel_error <= 1'b1;
            end
        end
    end

    // Output muxing from the FIFO head; everything is forced to zero while idle.
    always_comb begin
        w_head      = r_fifo[r_rd_ptr];
        w_head_data = w_head[DATA_W-1:0];
        w_head_idx  = w_head[ENTRY_W-1 -: ROW_W];
        px_valid    = w_px_valid;
        px_data     = 8'h00;
        px_row      = '0;
        px_col      = '0;
        px_sof      = 1'b0;
        px_eol      = 1'b0;
        px_eof      = 1'b0;
        if (w_px_valid) begin
            px_data = w_head_data[{r_col, 3'b000} +: 8];
            px_row  = w_head_idx;
            px_col  = r_col;
            px_sof  = (w_head_idx == '0) && (r_col == '0);
            px_eol  = (r_col == COL_LAST);
            px_eof  = (w_head_idx == ROW_LAST) && (r_col == COL_LAST);
        end else begin
            px_data = 8'h00;
        end
        overflow  = r_overflow;
        sel_error = r_sel_error;
    end

endmodule

// File: tb/tb_sensor_row_readout.sv
// Directed bench for sensor_row_readout: expected pixels are queued as rows are driven
// and checked against each accepted transfer.
module tb_sensor_row_readout;

    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [H-1:0] row_select = '0;
    logic [8*W-1:0] row_data = '0;
    logic         px_ready = 1'b0;
    logic [7:0]   px_data;
    logic         px_valid;
    logic [1:0]   px_row;
    logic [1:0]   px_col;
    logic         px_sof;
    logic         px_eol;
    logic         px_eof;
    logic         overflow;
    logic         sel_error;

    logic [14:0]  q[$];
    int           n_asserts = 0;
    int           n_fail = 0;
    int           n_xfer = 0;
    logic         hold_pend = 1'b0;
    logic [14:0]  held = '0;

    sensor_row_readout #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .row_select(row_select), .row_data(row_data),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_row(px_row), .px_col(px_col), .px_sof(px_sof), .px_eol(px_eol),
        .px_eof(px_eof), .overflow(overflow), .sel_error(sel_error)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {px_sof, px_eol, px_eof, px_row, px_col, px_data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_asserts++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [8*W-1:0] mkrow(input logic [7:0] base);
        logic [8*W-1:0] d;
        d = '0;
        for (int c = 0; c < W; c++) d[8*c +: 8] = base + 8'(c);
        return d;
    endfunction

    task automatic exp_row(input int idx, input logic [8*W-1:0] d);
        for (int c = 0; c < W; c++) begin
            q.push_back({(idx == 0 && c == 0), (c == W-1), (idx == H-1 && c == W-1),
                         2'(idx), 2'(c), d[8*c +: 8]});
        end
    endtask

    task automatic drive_row(input logic [H-1:0] sel, input logic [8*W-1:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            row_select = sel;
            row_data   = d;
        end
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((q.size() != 0 || px_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    // Scoreboard and back-pressure stability monitor.
    always @(negedge clk) begin
        if (reset && hold_pend) chk("hold_stable", 32'(obs()), 32'(held));
        if (reset && px_valid && px_ready) begin
            n_xfer <= n_xfer + 1;
            if (q.size() == 0) chk("unexpected_px", 32'(q.size()), 32'd1);
            else chk("pixel", 32'(obs()), 32'(q.pop_front()));
        end
        hold_pend <= reset && px_valid && !px_ready;
        held      <= obs();
    end

    initial begin
        int k;
        int bubbles;
        int base;
        logic [H-1:0] sel;

        @(negedge clk);
        chk("reset_outputs", 32'({px_valid, px_data, px_row, px_col, px_sof, px_eol, px_eof, overflow, sel_error}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        px_ready = 1'b1;

        // single row with latency check
        drive_row(4'b0001, 32'h04030201, 3);
        exp_row(0, 32'h04030201);
        @(posedge clk); #1;
        row_select = '0;
        @(negedge clk);
        chk("latency_before_commit", 32'(px_valid), 32'd0);
        @(negedge clk);
        chk("latency_after_commit", 32'(px_valid), 32'd1);
        wait_drain("drain_row0");
        chk("idle_after_row0", 32'(px_valid), 32'd0);

        // four rows back to back, no bubbles
        fork
            begin
                for (int r = 0; r < H; r++) begin
                    sel = 4'b0001 << r;
                    drive_row(sel, mkrow(8'(16 * r)), 4);
                    exp_row(r, mkrow(8'(16 * r)));
                end
                @(posedge clk); #1;
                row_select = '0;
            end
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!px_valid && k < 60);
                bubbles = 0;
                for (int i = 1; i < W * H; i++) begin
                    @(negedge clk);
                    if (!px_valid) bubbles++;
                end
                chk("no_bubble", 32'(bubbles), 32'd0);
            end
        join
        wait_drain("drain_frame");
        chk("no_overflow_frame", 32'(overflow), 32'd0);

        // non-one-hot select is dropped
        drive_row(4'b0011, 32'hDEADBEEF, 2);
        drive_row(4'b0000, 32'h0, 1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (px_valid) k++;
        end
        chk("sel_err_no_valid", 32'(k), 32'd0);
        chk("sel_error_set", 32'(sel_error), 32'd1);
        chk("sel_err_no_ovf", 32'(overflow), 32'd0);

        // valid row with random back-pressure
        drive_row(4'b0100, mkrow(8'h3C), 2);
        exp_row(2, mkrow(8'h3C));
        drive_row(4'b0000, 32'h0, 1);
        k = 0;
        while ((q.size() != 0 || px_valid) && k < 300) begin
            @(posedge clk); #1;
            px_ready = 1'($urandom_range(0, 1));
            k++;
        end
        px_ready = 1'b1;
        wait_drain("drain_random_ready");

        // overflow: three rows while stalled
        px_ready = 1'b0;
        drive_row(4'b0001, mkrow(8'hA0), 2);
        exp_row(0, mkrow(8'hA0));
        drive_row(4'b0010, mkrow(8'hB0), 2);
        exp_row(1, mkrow(8'hB0));
        drive_row(4'b0100, mkrow(8'hC0), 2);
        drive_row(4'b0000, 32'h0, 3);
        @(negedge clk);
        chk("overflow_set", 32'(overflow), 32'd1);
        base = n_xfer;
        @(posedge clk); #1;
        px_ready = 1'b1;
        wait_drain("drain_overflow");
        repeat (3) @(negedge clk);
        chk("overflow_px_count", 32'(n_xfer - base), 32'd8);

        // reset in the middle of a row
        drive_row(4'b0010, mkrow(8'h50), 2);
        exp_row(1, mkrow(8'h50));
        @(posedge clk); #1;
        row_select = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!px_valid && k < 20);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_row", 32'({px_valid, px_data, px_row, px_col, px_sof, px_eol, px_eof, overflow, sel_error}), 32'd0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (px_valid) k++;
        end
        chk("post_reset_silent", 32'(k), 32'd0);
        chk("post_reset_flags", 32'({overflow, sel_error}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
